stage5_field_extract: RTL

Parametrised, registered successor to the stage-5 single-field selector. It extracts one fixed-width field from each of `NUM_CH` parallel decoded messages. The bit position of the field depends on the message type code (a/d/k). Each channel has a valid/ready handshake, a 2-entry output skid buffer, and a saturating counter of unknown-type messages. The block sits between the stage-4 message decoder and the stage-6 order-book/field consumers.

---
 rtl/stage5_pkg.sv | 17 +
 rtl/stage5_field_extract_if.sv | 31 +++
 rtl/stage5_field_extract_ch.sv | 116 +++++++++++
 rtl/stage5_field_extract.sv | 57 +++++
 4 files changed

// File: rtl/stage5_pkg.sv
// Shared constants and types for the stage-5 field extractor: type codes,
// the default fill value and the FIFO entry layout at the default field width.
package stage5_pkg;

  localparam int unsigned MUX_A = 1;
  localparam int unsigned MUX_D = 2;
  localparam int unsigned MUX_K = 3;

  localparam int unsigned FIELD_W_DEF = 32;
  localparam logic [FIELD_W_DEF-1:0] DEFAULT_INFO = '0;

  typedef struct packed {
    logic                   hit;
    logic [FIELD_W_DEF-1:0] field;
  } field_entry_t;

endpackage

// File: rtl/stage5_field_extract_if.sv
// Bundles the per-channel input/output handshakes, data buses and the
// global enable/clear controls of the stage-5 field extractor.
interface stage5_field_extract_if #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned MSG_W   = 512,
  parameter int unsigned FIELD_W = 32,
  parameter int unsigned CTRL_W  = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                        message_en;
  logic                        cnt_clr;
  logic [NUM_CH-1:0]           in_valid;
  logic [NUM_CH-1:0]           in_ready;
  logic [NUM_CH*MSG_W-1:0]     message;
  logic [NUM_CH*CTRL_W-1:0]    mux_ctrl;
  logic [NUM_CH-1:0]           out_valid;
  logic [NUM_CH-1:0]           out_ready;
  logic [NUM_CH*FIELD_W-1:0]   field;
  logic [NUM_CH-1:0]           field_hit;
  logic [NUM_CH*CNT_W-1:0]     miss_cnt;

  modport master (
    output message_en, cnt_clr, in_valid, message, mux_ctrl, out_ready,
    input  in_ready, out_valid, field, field_hit, miss_cnt
  );

  modport slave (
    input  message_en, cnt_clr, in_valid, message, mux_ctrl, out_ready,
    output in_ready, out_valid, field, field_hit, miss_cnt
  );
endinterface

// File: rtl/stage5_field_extract_ch.sv
// One extractor channel: type-dependent field slice, 2-entry output skid
// FIFO and a saturating counter of unknown-type messages.
module stage5_field_extract_ch #(
  parameter int unsigned       MSG_W        = 512,
  parameter int unsigned       FIELD_W      = 32,
  parameter int unsigned       CTRL_W       = 2,
  parameter int unsigned       A_LSB        = 64,
  parameter int unsigned       D_LSB        = 96,
  parameter int unsigned       K_LSB        = 128,
  parameter logic [FIELD_W-1:0] DEFAULT_INFO = '0,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               message_en,
  input  logic               cnt_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MSG_W-1:0]   message,
  input  logic [CTRL_W-1:0]  mux_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] field,
  output logic               field_hit,
  output logic [CNT_W-1:0]   miss_cnt
);
  import stage5_pkg::*;

  typedef struct packed {
    logic               hit;
    logic [FIELD_W-1:0] field;
  } entry_t;

  localparam entry_t ResetEntry = '{hit: 1'b0, field: DEFAULT_INFO};

  entry_t             new_entry, head_q, head_d, tail_q, tail_d;
  logic [FIELD_W-1:0] sel_field;
  logic               known;
  logic [1:0]         count_q, count_d;
  logic               ready_q;
  logic [CNT_W-1:0]   miss_q, miss_d;
  logic               push, pop;

  // Only three slices of the message are ever read.
  logic unused_msg;
  assign unused_msg = ^message;

  always_comb begin
    sel_field = DEFAULT_INFO;
    known     = 1'b0;
    case (mux_ctrl)
      CTRL_W'(MUX_A): begin sel_field = message[A_LSB +: FIELD_W]; known = 1'b1; end
      CTRL_W'(MUX_D): begin sel_field = message[D_LSB +: FIELD_W]; known = 1'b1; end
      CTRL_W'(MUX_K): begin sel_field = message[K_LSB +: FIELD_W]; known = 1'b1; end
      default:        begin sel_field = DEFAULT_INFO;              known = 1'b0; end
    endcase
    new_entry.hit   = message_en & known;
    new_entry.field = new_entry.hit ? sel_field : DEFAULT_INFO;
  end

  // ready_q keeps in_ready low during reset and for no longer than one edge after.
  assign in_ready  = ready_q & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign field     = head_q.field;
  assign field_hit = head_q.hit;
  assign miss_cnt  = miss_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: if (push) begin head_d = new_entry; count_d = 2'd1; end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: if (pop) begin head_d = tail_q; count_d = 2'd1; end
      default: count_d = 2'd0;
    endcase
  end

  always_comb begin
    miss_d = miss_q;
    if (cnt_clr) begin
      miss_d = '0;
    end else if (push && message_en && !known && (miss_q != '1)) begin
      miss_d = miss_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ready_q <= 1'b0;
      head_q  <= ResetEntry;
      tail_q  <= ResetEntry;
      miss_q  <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= 1'b1;
      head_q  <= head_d;
      tail_q  <= tail_d;
      miss_q  <= miss_d;
    end
  end

endmodule

// File: rtl/stage5_field_extract.sv
// Stage-5 field extractor top: slices the channel buses from the interface
// and instantiates one independent extractor per channel.
module stage5_field_extract #(
  parameter int unsigned        NUM_CH       = 3,
  parameter int unsigned        MSG_W        = 512,
  parameter int unsigned        FIELD_W      = 32,
  parameter int unsigned        CTRL_W       = 2,
  parameter int unsigned        A_LSB        = 64,
  parameter int unsigned        D_LSB        = 96,
  parameter int unsigned        K_LSB        = 128,
  parameter logic [FIELD_W-1:0] DEFAULT_INFO = FIELD_W'(stage5_pkg::DEFAULT_INFO),
  parameter int unsigned        CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  stage5_field_extract_if.slave bus
);
  import stage5_pkg::*;

  if (A_LSB + FIELD_W > MSG_W) begin : gen_err_a
    $error("A_LSB + FIELD_W exceeds MSG_W");
  end
  if (D_LSB + FIELD_W > MSG_W) begin : gen_err_d
    $error("D_LSB + FIELD_W exceeds MSG_W");
  end
  if (K_LSB + FIELD_W > MSG_W) begin : gen_err_k
    $error("K_LSB + FIELD_W exceeds MSG_W");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    stage5_field_extract_ch #(
      .MSG_W        (MSG_W),
      .FIELD_W      (FIELD_W),
      .CTRL_W       (CTRL_W),
      .A_LSB        (A_LSB),
      .D_LSB        (D_LSB),
      .K_LSB        (K_LSB),
      .DEFAULT_INFO (DEFAULT_INFO),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .message_en (bus.message_en),
      .cnt_clr    (bus.cnt_clr),
      .in_valid   (bus.in_valid[c]),
      .in_ready   (bus.in_ready[c]),
      .message    (bus.message[c*MSG_W +: MSG_W]),
      .mux_ctrl   (bus.mux_ctrl[c*CTRL_W +: CTRL_W]),
      .out_valid  (bus.out_valid[c]),
      .out_ready  (bus.out_ready[c]),
      .field      (bus.field[c*FIELD_W +: FIELD_W]),
      .field_hit  (bus.field_hit[c]),
      .miss_cnt   (bus.miss_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule
